pulse_frame_streamer: RTL and testbench

Downstream consumer of the gamma pulse generator. When the generator reports a finished frame, this block scans the pulse BRAM from word 0 to the last word. Each fp32 sample is converted to unsigned fixed-point, saturated to the output width, and streamed out on a valid/ready interface. Each word is cleared to zero after it is read, so the next generated frame accumulates onto a clean memory.

---
 rtl/pulse_frame_streamer.sv | 214 +++++++++++++++++++++
 tb/tb_pulse_frame_streamer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_frame_streamer.sv
// pulse_frame_streamer
// Scans the pulse BRAM once per finished generator frame, converts each fp32
// word to saturated unsigned fixed point, streams it on a valid/ready port and
// optionally clears the word behind itself so the next frame starts clean.

module pulse_frame_streamer #(
    parameter int DEPTH         = 2064,
    parameter int OUT_W         = 16,
    parameter int FRAC          = 12,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       finish_pulse_gen,
    output logic [31:0]      bram_addr_rd,
    output logic [31:0]      bram_data_in_rd,
    output logic             bram_we_rd,
    output logic             ena_rd,
    input  logic [31:0]      bram_data_out_pulse,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             sample_last,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_abort,
    output logic [15:0]      sat_count
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                WIDE_W   = OUT_W + 24;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [OUT_W-1:0]  SAT_VAL  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        prev_fin_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OUT_W-1:0]  sample_data_q, sample_data_d;
    logic              sample_last_q, sample_last_d;
    logic [15:0]       sat_count_q, sat_count_d;
    logic              frame_abort_q, frame_abort_d;

    logic              start;
    logic              abort;

    logic              fp_sign;
    logic [7:0]        fp_exp;
    logic [22:0]       fp_mant;
    int                shift_k;
    logic [WIDE_W-1:0] mant_wide;
    logic [WIDE_W-1:0] shifted;
    logic [OUT_W-1:0]  conv_value;
    logic              conv_sat;

    // A scan starts only on the rising transition into "frame complete";
    // leaving that status while a scan is active aborts it.
    assign start = (finish_pulse_gen == 2'b11) && (prev_fin_q != 2'b11);
    assign abort = (finish_pulse_gen != 2'b11);

    assign bram_addr_rd    = {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
    assign bram_data_in_rd = 32'd0;
    assign sample_data     = sample_data_q;
    assign sample_last     = sample_last_q;
    assign sat_count       = sat_count_q;
    assign frame_abort     = frame_abort_q;

    // fp32 to unsigned fixed point: negatives, zeros and denormals give 0,
    // Inf/NaN and out-of-range magnitudes clamp to full scale.
    always_comb begin
        fp_sign    = bram_data_out_pulse[31];
        fp_exp     = bram_data_out_pulse[30:23];
        fp_mant    = bram_data_out_pulse[22:0];
        shift_k    = int'({24'd0, fp_exp}) - 127 + FRAC;
        mant_wide  = WIDE_W'({1'b1, fp_mant});
        shifted    = '0;
        conv_value = '0;
        conv_sat   = 1'b0;
        if ((fp_exp == 8'd0) || fp_sign) begin
            conv_value = '0;
        end else if (fp_exp == 8'hFF) begin
            conv_value = SAT_VAL;
            conv_sat   = 1'b1;
        end else if (shift_k < 0) begin
            conv_value = '0;
        end else if (shift_k >= OUT_W) begin
            conv_value = SAT_VAL;
            conv_sat   = 1'b1;
        end else begin
            if (shift_k >= 23) begin
                shifted = mant_wide << (shift_k - 23);
            end else begin
                shifted = mant_wide >> (23 - shift_k);
            end
            if (|shifted[WIDE_W-1:OUT_W]) begin
                conv_value = SAT_VAL;
                conv_sat   = 1'b1;
            end else begin
                conv_value = shifted[OUT_W-1:0];
            end
        end
    end

    // Next-state and strobe decode; strobes come straight from the state so
    // they are glitch-free and drop as soon as the FSM returns to IDLE.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sample_data_d = sample_data_q;
        sample_last_d = sample_last_q;
        sat_count_d   = sat_count_q;
        frame_abort_d = 1'b0;
        ena_rd        = 1'b0;
        bram_we_rd    = 1'b0;
        sample_valid  = 1'b0;
        busy          = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RD;
                    idx_d       = '0;
                    sat_count_d = '0;
                end
            end
            ST_RD: begin
                busy   = 1'b1;
                ena_rd = 1'b1;
                if (abort) begin
                    state_d       = ST_IDLE;
                    frame_abort_d = 1'b1;
                end else begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                busy = 1'b1;
                if (CLEAR_ON_READ != 0) begin
                    ena_rd     = 1'b1;
                    bram_we_rd = 1'b1;
                end
                if (abort) begin
                    state_d       = ST_IDLE;
                    frame_abort_d = 1'b1;
                end else begin
                    sample_data_d = conv_value;
                    sample_last_d = (idx_q == LAST_IDX);
                    if (conv_sat && (sat_count_q != 16'hFFFF)) begin
                        sat_count_d = sat_count_q + 16'd1;
                    end
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                busy         = 1'b1;
                sample_valid = 1'b1;
                if (abort) begin
                    state_d       = ST_IDLE;
                    frame_abort_d = 1'b1;
                end else if (sample_ready) begin
                    if (sample_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: word index, held sample, counters and status history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_fin_q    <= 2'b00;
            idx_q         <= '0;
            sample_data_q <= '0;
            sample_last_q <= 1'b0;
            sat_count_q   <= '0;
            frame_abort_q <= 1'b0;
        end else begin
            prev_fin_q    <= finish_pulse_gen;
            idx_q         <= idx_d;
            sample_data_q <= sample_data_d;
            sample_last_q <= sample_last_d;
            sat_count_q   <= sat_count_d;
            frame_abort_q <= frame_abort_d;
        end
    end

endmodule

// File: tb/tb_pulse_frame_streamer.sv
// tb_pulse_frame_streamer
// Directed bench with a 4-word read-first BRAM model: table-driven conversion
// frames plus hand-written backpressure, re-arm, abort and reset sequences.

module tb_pulse_frame_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  finish_pulse_gen = 2'b00;
    logic [31:0] bram_addr_rd;
    logic [31:0] bram_data_in_rd;
    logic        bram_we_rd;
    logic        ena_rd;
    logic [31:0] bram_data_out_pulse = 32'd0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        sample_last;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic [15:0] sat_count;

    typedef struct {
        logic [31:0] word;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] mem [4];
    logic [31:0] load_vals [4];
    logic        load_req = 1'b0;
    int          acc_count = 0;
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    pulse_frame_streamer #(
        .DEPTH(4),
        .OUT_W(16),
        .FRAC(12),
        .CLEAR_ON_READ(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .finish_pulse_gen(finish_pulse_gen),
        .bram_addr_rd(bram_addr_rd),
        .bram_data_in_rd(bram_data_in_rd),
        .bram_we_rd(bram_we_rd),
        .ena_rd(ena_rd),
        .bram_data_out_pulse(bram_data_out_pulse),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_last(sample_last),
        .busy(busy),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with registered output; also tallies accesses and writes.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 4; i++) mem[i] <= load_vals[i];
        end else if (ena_rd) begin
            acc_count <= acc_count + 1;
            if (bram_we_rd) begin
                mem[bram_addr_rd[3:2]] <= bram_data_in_rd;
                wr_count <= wr_count + 1;
            end
            bram_data_out_pulse <= mem[bram_addr_rd[3:2]];
        end
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        load_vals[0] = w0;
        load_vals[1] = w1;
        load_vals[2] = w2;
        load_vals[3] = w3;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] pre_fin);
        finish_pulse_gen = pre_fin;
        @(negedge clk);
        finish_pulse_gen = 2'b11;
    endtask

    // Runs one full frame over vecs[base..base+3], optionally stalling ready
    // for stall_len cycles when word stall_word is offered.
    task automatic run_frame(input int base, input logic [1:0] pre_fin,
                             input int stall_word, input int stall_len, input int exp_done);
        int          acc0;
        int          n_got;
        int          stall_left;
        int          done_cyc;
        logic [15:0] snap;
        logic [15:0] got_data [4];
        logic        got_last [4];
        logic [15:0] exp_sat_cnt;
        exp_sat_cnt = 16'd0;
        for (int i = 0; i < 4; i++) if (vecs[base+i].exp_sat) exp_sat_cnt++;
        load_mem(vecs[base].word, vecs[base+1].word, vecs[base+2].word, vecs[base+3].word);
        start_frame(pre_fin);
        acc0       = acc_count;
        n_got      = 0;
        stall_left = stall_len;
        done_cyc   = 0;
        snap       = 16'd0;
        sample_ready = 1'b1;
        for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_output("first_ena", ena_rd, 1'b1);
                check_output("first_we", bram_we_rd, 1'b0);
                check_output("first_addr", bram_addr_rd, 32'd0);
                check_output("first_sat_clear", sat_count, 16'd0);
                check_output("first_busy", busy, 1'b1);
            end
            if (frame_done) begin
                done_cyc = cyc;
                check_output("done_busy", busy, 1'b0);
            end
            if (sample_valid) begin
                if (n_got == stall_word && stall_left > 0) begin
                    sample_ready = 1'b0;
                    if (stall_left == stall_len) snap = sample_data;
                    else check_output("stall_data_stable", sample_data, snap);
                    stall_left--;
                end else begin
                    sample_ready = 1'b1;
                    if (n_got < 4) begin
                        got_data[n_got] = sample_data;
                        got_last[n_got] = sample_last;
                    end
                    n_got++;
                end
            end else begin
                sample_ready = 1'b1;
            end
        end
        sample_ready = 1'b1;
        check_output("done_latency", done_cyc, exp_done);
        check_output("sample_count", n_got, 4);
        for (int i = 0; i < 4 && i < n_got; i++) begin
            check_output($sformatf("data_v%0d", base + i), got_data[i], vecs[base+i].exp_data);
            check_output($sformatf("last_v%0d", base + i), got_last[i], (i == 3));
        end
        check_output("sat_count", sat_count, exp_sat_cnt);
        check_output("bram_accesses", acc_count - acc0, 8);
        for (int i = 0; i < 4; i++) check_output($sformatf("cleared_w%0d", i), mem[i], 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc0;
        int wr0;
        int nv;
        int busy_cnt;
        int done_cnt;
        logic aborted;

        vecs[0]  = '{32'h3F800000, 16'd4096,  1'b0};
        vecs[1]  = '{32'h3E99652C, 16'd1227,  1'b0};
        vecs[2]  = '{32'hBF800000, 16'd0,     1'b0};
        vecs[3]  = '{32'h41A00000, 16'd65535, 1'b1};
        vecs[4]  = '{32'h7FC00000, 16'd65535, 1'b1};
        vecs[5]  = '{32'h00000001, 16'd0,     1'b0};
        vecs[6]  = '{32'h417FFFFF, 16'd65535, 1'b0};
        vecs[7]  = '{32'h41800000, 16'd65535, 1'b1};
        vecs[8]  = '{32'h39800000, 16'd1,     1'b0};
        vecs[9]  = '{32'h39000000, 16'd0,     1'b0};
        vecs[10] = '{32'h7F800000, 16'd65535, 1'b1};
        vecs[11] = '{32'h80000000, 16'd0,     1'b0};

        #2 rst_n = 1'b0;
        #1;
        check_output("reset_outputs",
            {bram_addr_rd, bram_data_in_rd, bram_we_rd, ena_rd, sample_data, sample_valid,
             sample_last, busy, frame_done, frame_abort, sat_count}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] frames with table vectors");
        run_frame(0, 2'b01, -1, 0, 13);
        run_frame(4, 2'b01, -1, 0, 13);
        run_frame(8, 2'b01, 1, 5, 18);

        $display("[TB] re-arm: level held at 11");
        load_mem(vecs[0].word, vecs[1].word, vecs[2].word, vecs[3].word);
        acc0 = acc_count;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check_output("hold_no_access", acc_count - acc0, 0);
        check_output("hold_no_busy", busy_cnt, 0);
        run_frame(0, 2'b00, -1, 0, 13);

        $display("[TB] abort during word 2 output");
        load_mem(32'h7FC00000, 32'h3F800000, 32'h41800000, 32'h3F800000);
        start_frame(2'b01);
        nv = 0;
        aborted = 1'b0;
        for (int cyc = 0; cyc < 40 && !aborted; cyc++) begin
            @(negedge clk);
            if (sample_valid) begin
                if (nv == 2) begin
                    finish_pulse_gen = 2'b01;
                    aborted = 1'b1;
                end
                nv++;
            end
        end
        check_output("abort_reached", aborted, 1'b1);
        @(negedge clk);
        check_output("abort_pulse", frame_abort, 1'b1);
        check_output("abort_valid", sample_valid, 1'b0);
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_ena", {ena_rd, bram_we_rd}, 2'b00);
        check_output("abort_sat_partial", sat_count, 16'd2);
        done_cnt = frame_done ? 1 : 0;
        @(negedge clk);
        check_output("abort_pulse_end", frame_abort, 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (frame_done) done_cnt++;
        end
        check_output("abort_no_done", done_cnt, 0);
        for (int i = 0; i < 3; i++) check_output($sformatf("abort_cleared_w%0d", i), mem[i], 32'd0);
        check_output("abort_w3_intact", mem[3], 32'h3F800000);

        $display("[TB] asynchronous reset mid-scan");
        load_mem(vecs[0].word, vecs[1].word, vecs[2].word, vecs[3].word);
        start_frame(2'b01);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        finish_pulse_gen = 2'b00;
        #1;
        check_output("midscan_reset_outputs",
            {bram_addr_rd, bram_data_in_rd, bram_we_rd, ena_rd, sample_data, sample_valid,
             sample_last, busy, frame_done, frame_abort, sat_count}, 128'd0);
        acc0 = acc_count;
        wr0 = wr_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("post_reset_no_write", wr_count - wr0, 0);
        check_output("post_reset_no_access", acc_count - acc0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
